rle_decoder: RTL and testbench

RLE_DECODER -- requirements
Module: rle_decoder

---
 rtl/rle_decoder_if.sv | 26 ++
 rtl/rle_decoder.sv | 176 +++++++++++++++++
 tb/tb_rle_decoder.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rle_decoder_if.sv
// rle_decoder_if -- byte stream handshake bundle for the RLE decoder.
//
// Source side : src_pixel / src_pixel_write flow into the decoder,
//               src_pixel_strobe flows back when the byte is consumed.
// Sink side   : dst_pixel / dst_pixel_write flow out of the decoder,
//               dst_pixel_strobe flows back when the sink accepts a pixel.
// The slave modport is the decoder view; master is the view of whatever
// feeds the source and drains the sink.
interface rle_decoder_if;
    logic [7:0] src_pixel;
    logic       src_pixel_write;
    logic       src_pixel_strobe;
    logic [7:0] dst_pixel;
    logic       dst_pixel_write;
    logic       dst_pixel_strobe;

    modport slave (
        input  src_pixel, src_pixel_write, dst_pixel_strobe,
        output src_pixel_strobe, dst_pixel, dst_pixel_write
    );

    modport master (
        output src_pixel, src_pixel_write, dst_pixel_strobe,
        input  src_pixel_strobe, dst_pixel, dst_pixel_write
    );
endinterface

// File: rtl/rle_decoder.sv
// rle_decoder -- run-length decoder for CLUT7 (RL7) and 3-bit pair (RL3)
// pixel streams, producing a fixed number of pixels per line.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   mode        0 = RL7, 1 = RL3; sampled at reset, line_start and line reload
//   line_start  synchronous restart of the current line
//   line_done   one-cycle pulse after the last pixel of a line transfers
//   bus         rle_decoder_if.slave: source byte and destination pixel handshakes
//
// Literal pixels are forwarded combinationally from the source byte; run
// pixels come from a stored copy of the run header byte.
module rle_decoder #(
    parameter int LINE_PIXELS = 384,
    parameter int CNT_W       = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mode,
    input  logic         line_start,
    output logic         line_done,
    rle_decoder_if.slave bus
);
    localparam logic [2:0] ST_SINGLE    = 3'd0;
    localparam logic [2:0] ST_PAIR_B    = 3'd1;
    localparam logic [2:0] ST_GET_COUNT = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_RUN_EOL   = 3'd4;

    localparam logic [CNT_W-1:0] LINE_RELOAD = CNT_W'(LINE_PIXELS);

    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] line_cnt;
    logic [7:0]       run_cnt, run_cnt_nxt;
    logic             phase, phase_nxt;    // RL3 run slot: 0 = A, 1 = B
    logic             mode_q;
    logic [6:0]       run_byte;
    logic             store_run;
    logic             line_wrap;

    logic [7:0]       src_byte;
    logic             src_write;
    logic             dst_strobe;
    logic             src_strobe;
    logic             dst_write;
    logic [7:0]       dst_pixel;
    logic             last_slot;

    assign src_byte   = bus.src_pixel;
    assign src_write  = bus.src_pixel_write;
    assign dst_strobe = bus.dst_pixel_strobe;

    assign bus.src_pixel_strobe = src_strobe;
    assign bus.dst_pixel_write  = dst_write;
    assign bus.dst_pixel        = dst_pixel;

    assign last_slot = (line_cnt == CNT_W'(1));

    always_comb begin
        src_strobe  = 1'b0;
        dst_write   = 1'b0;
        dst_pixel   = 8'd0;
        state_nxt   = state;
        run_cnt_nxt = run_cnt;
        phase_nxt   = phase;
        store_run   = 1'b0;
        line_wrap   = 1'b0;

        case (state)
            ST_SINGLE: begin
                if (src_byte[7]) begin
                    // Run header: swallow it, keep its pixel(s), wait for the count.
                    src_strobe = src_write;
                    store_run  = src_write;
                    if (src_write) state_nxt = ST_GET_COUNT;
                end else if (!mode_q) begin
                    dst_pixel  = {1'b0, src_byte[6:0]};
                    dst_write  = src_write;
                    src_strobe = src_write && dst_strobe;
                end else begin
                    // RL3 literal: A goes out first and the byte is held for B,
                    // unless A fills the line, in which case B is dropped.
                    dst_pixel  = {5'd0, src_byte[6:4]};
                    dst_write  = src_write;
                    src_strobe = src_write && dst_strobe && last_slot;
                    if (src_write && dst_strobe && !last_slot) state_nxt = ST_PAIR_B;
                end
            end

            ST_PAIR_B: begin
                dst_pixel  = {5'd0, src_byte[2:0]};
                dst_write  = src_write;
                src_strobe = src_write && dst_strobe;
                if (src_write && dst_strobe) state_nxt = ST_SINGLE;
            end

            ST_GET_COUNT: begin
                src_strobe = src_write;
                if (src_write) begin
                    run_cnt_nxt = src_byte;
                    phase_nxt   = 1'b0;
                    state_nxt   = (src_byte == 8'd0) ? ST_RUN_EOL : ST_RUN;
                end
            end

            ST_RUN, ST_RUN_EOL: begin
                dst_write = 1'b1;
                if (!mode_q)    dst_pixel = {1'b0, run_byte};
                else if (phase) dst_pixel = {5'd0, run_byte[2:0]};
                else            dst_pixel = {5'd0, run_byte[6:4]};
                if (dst_strobe) begin
                    if (mode_q) phase_nxt = ~phase;
                    // RL3 counts pairs, so only the B slot retires a count.
                    if (state == ST_RUN && (!mode_q || phase)) begin
                        run_cnt_nxt = run_cnt - 8'd1;
                        if (run_cnt == 8'd1) begin
                            state_nxt = ST_SINGLE;
                            phase_nxt = 1'b0;
                        end
                    end
                end
            end

            default: state_nxt = ST_SINGLE;
        endcase

        // Nothing may handshake while the line is being restarted or reset.
        if (line_start || reset) begin
            dst_write  = 1'b0;
            src_strobe = 1'b0;
        end

        // The last pixel of a line cuts off whatever run is in progress.
        if (dst_write && dst_strobe && last_slot) begin
            line_wrap   = 1'b1;
            state_nxt   = ST_SINGLE;
            run_cnt_nxt = 8'd0;
            phase_nxt   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_SINGLE;
            line_cnt  <= LINE_RELOAD;
            run_cnt   <= 8'd0;
            phase     <= 1'b0;
            mode_q    <= mode;
            line_done <= 1'b0;
        end else if (line_start) begin
            state     <= ST_SINGLE;
            line_cnt  <= LINE_RELOAD;
            run_cnt   <= 8'd0;
            phase     <= 1'b0;
            mode_q    <= mode;
            line_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            run_cnt   <= run_cnt_nxt;
            phase     <= phase_nxt;
            line_done <= line_wrap;
            if (line_wrap) begin
                line_cnt <= LINE_RELOAD;
                mode_q   <= mode;
            end else if (dst_write && dst_strobe) begin
                line_cnt <= line_cnt - CNT_W'(1);
            end
        end
    end

    // Run pixel storage is plain data; it is only read after being written.
    always_ff @(posedge clk) begin
        if (store_run) run_byte <= src_byte[6:0];
    end
endmodule

// File: tb/tb_rle_decoder.sv
// tb_rle_decoder -- self-checking bench for rle_decoder.
// Directed steps plus randomized byte streams, compared against a
// transaction-level decoding model of the byte stream.
`timescale 1ns/1ps
module tb_rle_decoder;
    localparam int LP = 384;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mode = 1'b0;
    logic line_start = 1'b0;
    logic line_done;

    rle_decoder_if bus ();

    rle_decoder #(.LINE_PIXELS(LP), .CNT_W(11)) dut (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode),
        .line_start (line_start),
        .line_done  (line_done),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] src_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int exp_done;
    int last_dones;
    int m_left;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Model: one pixel occupies one line slot; the last slot wraps the line.
    function automatic bit emit(input logic [7:0] p);
        exp_q.push_back(p);
        m_left--;
        if (m_left == 0) begin
            m_left = LP;
            exp_done++;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic build_model(input bit m, input int left0);
        int i = 0;
        int j;
        int total;
        bit w;
        logic [7:0] b, pa, pb;
        exp_q.delete();
        exp_done = 0;
        m_left = left0;
        while (i < src_q.size()) begin
            b  = src_q[i];
            pa = m ? {5'd0, b[6:4]} : {1'b0, b[6:0]};
            pb = m ? {5'd0, b[2:0]} : pa;
            if (!b[7]) begin
                w = emit(pa);
                if (m && !w) w = emit(pb);
                i++;
            end else begin
                total = m ? 2 * int'(src_q[i+1]) : int'(src_q[i+1]);
                i += 2;
                j = 0;
                // A zero count keeps repeating until the line is full.
                while (total == 0 || j < total) begin
                    w = emit((j % 2 == 1) ? pb : pa);
                    j++;
                    if (w) break;
                end
            end
        end
    endtask

    task automatic gen_random(input int ntok);
        src_q.delete();
        for (int t = 0; t < ntok; t++) begin
            if ($urandom_range(99) < 70) begin
                src_q.push_back(8'($urandom_range(127)));
            end else begin
                src_q.push_back(8'(128 + $urandom_range(127)));
                src_q.push_back(($urandom_range(9) == 0) ? 8'd0 : 8'($urandom_range(12, 1)));
            end
        end
    endtask

    task automatic fill_literals(input int n);
        src_q.delete();
        for (int t = 0; t < n; t++) src_q.push_back(8'(t % 128));
    endtask

    // Feeds src_q with valid-hold handshaking, drains with a random strobe,
    // and checks every transferred pixel against the model.
    task automatic stream(input bit m, input int left0, input bit do_ls,
                          input int vld_pct, input int stb_pct);
        int idx = 0;
        int k = 0;
        int cyc = 0;
        int dones = 0;
        bit presenting = 1'b0;
        bit prev_stall = 1'b0;
        logic [7:0] prev_pix = 8'd0;
        build_model(m, left0);
        obs_q.delete();
        if (do_ls) begin
            mode = m;
            line_start = 1'b1;
            bus.src_pixel_write = 1'b0;
            bus.dst_pixel_strobe = 1'b0;
            @(negedge clk);
            line_start = 1'b0;
        end
        while ((idx < src_q.size() || k < exp_q.size()) && cyc < 20000) begin
            if (!presenting && idx < src_q.size() && $urandom_range(99) < vld_pct) presenting = 1'b1;
            bus.src_pixel_write  = presenting;
            bus.src_pixel        = presenting ? src_q[idx] : 8'($urandom_range(255));
            bus.dst_pixel_strobe = ($urandom_range(99) < stb_pct);
            #1;
            if (line_done) dones++;
            if (prev_stall) begin
                check("stall_write_held", bus.dst_pixel_write, 1);
                check("stall_pixel_held", bus.dst_pixel, prev_pix);
            end
            if (!presenting) check("strobe_without_write", bus.src_pixel_strobe, 0);
            if (bus.dst_pixel_write && bus.dst_pixel_strobe) begin
                if (k < exp_q.size()) check("pixel", bus.dst_pixel, exp_q[k]);
                else check("pixel_overrun", k, exp_q.size());
                obs_q.push_back(bus.dst_pixel);
                k++;
            end
            prev_stall = bus.dst_pixel_write && !bus.dst_pixel_strobe;
            prev_pix   = bus.dst_pixel;
            if (bus.src_pixel_strobe) begin
                idx++;
                presenting = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.src_pixel_write  = 1'b0;
        bus.dst_pixel_strobe = 1'b1;
        for (int d = 0; d < 3; d++) begin
            #1;
            if (line_done) dones++;
            check("idle_after_stream", bus.dst_pixel_write, 0);
            @(negedge clk);
        end
        check("bytes_consumed", idx, src_q.size());
        check("pixels_out", k, exp_q.size());
        check("line_done_count", dones, exp_done);
        last_dones = dones;
    endtask

    initial begin
        bus.src_pixel        = 8'd0;
        bus.src_pixel_write  = 1'b0;
        bus.dst_pixel_strobe = 1'b0;
        reset = 1'b1;
        mode  = 1'b0;
        repeat (2) @(negedge clk);

        // Reset: outputs stay quiet even with an active source and sink.
        bus.src_pixel = 8'h05;
        bus.src_pixel_write = 1'b1;
        bus.dst_pixel_strobe = 1'b1;
        #1;
        check("reset_dst_write", bus.dst_pixel_write, 0);
        check("reset_src_strobe", bus.src_pixel_strobe, 0);
        check("reset_line_done", line_done, 0);
        @(negedge clk);
        reset = 1'b0;

        // RL7 literal passes through in the same cycle.
        #1;
        check("lit_pixel", bus.dst_pixel, 8'h05);
        check("lit_write", bus.dst_pixel_write, 1);
        check("lit_strobe", bus.src_pixel_strobe, 1);
        @(negedge clk);
        bus.src_pixel_write = 1'b0;

        // RL7 run of four, free-flowing then with sink stalls.
        src_q = '{8'h83, 8'h04};
        stream(1'b0, LP, 1'b1, 100, 100);
        check("rl7_run_len", obs_q.size(), 4);
        for (int i = 0; i < 4; i++) check("rl7_run_pix", obs_q[i], 8'h03);
        src_q = '{8'h83, 8'h04};
        stream(1'b0, LP, 1'b1, 100, 40);
        check("rl7_run_stall_len", obs_q.size(), 4);

        // RL7 end-of-line run fills the last four slots; next byte is a literal.
        fill_literals(380);
        src_q.push_back(8'h85);
        src_q.push_back(8'h00);
        src_q.push_back(8'h2A);
        stream(1'b0, LP, 1'b1, 100, 100);
        for (int i = 380; i < 384; i++) check("eol_run_pix", obs_q[i], 8'h05);
        check("eol_next_literal", obs_q[384], 8'h2A);
        check("eol_line_done", last_dones, 1);

        // RL3 literal: A, then B; byte consumed only with B.
        @(negedge clk);
        mode = 1'b1;
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        bus.src_pixel = 8'h35;
        bus.src_pixel_write = 1'b1;
        bus.dst_pixel_strobe = 1'b1;
        #1;
        check("rl3_a_pixel", bus.dst_pixel, 8'h03);
        check("rl3_a_write", bus.dst_pixel_write, 1);
        check("rl3_a_no_consume", bus.src_pixel_strobe, 0);
        @(negedge clk);
        #1;
        check("rl3_b_pixel", bus.dst_pixel, 8'h05);
        check("rl3_b_consume", bus.src_pixel_strobe, 1);
        @(negedge clk);
        bus.src_pixel_write = 1'b0;
        #1;
        check("rl3_back_idle", bus.dst_pixel_write, 0);
        @(negedge clk);

        // RL3 run of two pairs.
        src_q = '{8'hA1, 8'h02};
        stream(1'b1, LP, 1'b1, 100, 100);
        check("rl3_run_len", obs_q.size(), 4);
        check("rl3_run_p0", obs_q[0], 8'h02);
        check("rl3_run_p1", obs_q[1], 8'h01);
        check("rl3_run_p2", obs_q[2], 8'h02);
        check("rl3_run_p3", obs_q[3], 8'h01);

        // RL3 run cut off by the end of the line.
        fill_literals(190);
        src_q.push_back(8'h9A);
        src_q.push_back(8'h05);
        src_q.push_back(8'h35);
        stream(1'b1, LP, 1'b1, 100, 100);
        check("rl3_trunc_p380", obs_q[380], 8'h01);
        check("rl3_trunc_p383", obs_q[383], 8'h02);
        check("rl3_trunc_next_a", obs_q[384], 8'h03);
        check("rl3_trunc_next_b", obs_q[385], 8'h05);

        // Randomized streams in both modes.
        for (int r = 0; r < 6; r++) begin
            gen_random(60 + int'($urandom_range(60)));
            stream((r % 2) == 1, LP, 1'b1, int'($urandom_range(100, 40)), int'($urandom_range(100, 40)));
        end

        // Reset in the middle of an RL7 run.
        mode = 1'b0;
        line_start = 1'b1;
        bus.src_pixel_write = 1'b0;
        @(negedge clk);
        line_start = 1'b0;
        bus.src_pixel = 8'h81;
        bus.src_pixel_write = 1'b1;
        bus.dst_pixel_strobe = 1'b1;
        #1;
        check("mid_hdr_strobe", bus.src_pixel_strobe, 1);
        check("mid_hdr_no_pixel", bus.dst_pixel_write, 0);
        @(negedge clk);
        bus.src_pixel = 8'h0A;
        #1;
        check("mid_cnt_strobe", bus.src_pixel_strobe, 1);
        @(negedge clk);
        bus.src_pixel_write = 1'b0;
        for (int t = 0; t < 3; t++) begin
            #1;
            check("mid_run_pixel", bus.dst_pixel, 8'h01);
            check("mid_run_write", bus.dst_pixel_write, 1);
            @(negedge clk);
        end
        reset = 1'b1;
        bus.src_pixel = 8'h07;
        bus.src_pixel_write = 1'b1;
        #1;
        check("mid_reset_write", bus.dst_pixel_write, 0);
        check("mid_reset_strobe", bus.src_pixel_strobe, 0);
        check("mid_reset_line_done", line_done, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_reset_pixel", bus.dst_pixel, 8'h07);
        check("post_reset_write", bus.dst_pixel_write, 1);
        check("post_reset_strobe", bus.src_pixel_strobe, 1);
        @(negedge clk);
        bus.src_pixel_write = 1'b0;
        fill_literals(383);
        stream(1'b0, 383, 1'b0, 100, 100);
        check("post_reset_line_len", last_dones, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
